// File: rtl/drive_cmd_sequencer_if.sv
// Drive command bundle: raw board inputs in, drive command to speed_display out.
// Latency: n/a (signal grouping only).
// Backpressure: none; the consumer samples the command on the read_enable rising edge.
interface drive_cmd_sequencer_if;
    logic [3:0] key_n;        // raw buttons, active-low: [0]=fwd [1]=back [2]=left [3]=right
    logic [2:0] sw_torque;    // raw torque switches
    logic       sw_enable;    // raw enable switch
    logic [1:0] instruction;  // 00 fwd, 01 back, 10 left, 11 right
    logic [2:0] torque;       // clamped 0..4
    logic       read_enable;  // command strobe
    logic       enable;       // debounced sw_enable
    logic       busy;         // sequencer not idle
    logic [7:0] cmd_count;    // commands issued, wraps

    // Sequencer side: consumes board inputs, produces the command.
    modport master (
        input  key_n, sw_torque, sw_enable,
        output instruction, torque, read_enable, enable, busy, cmd_count
    );

    // Board/consumer side.
    modport slave (
        output key_n, sw_torque, sw_enable,
        input  instruction, torque, read_enable, enable, busy, cmd_count
    );
endinterface

// File: rtl/drive_cmd_sequencer.sv
// Debounces DE2 keys/switches and issues one drive command (instruction/torque + read_enable strobe) per press.
// Latency: strobe rises 2 sync + DEBOUNCE_CYCLES + 1 + SETUP_CYCLES cycles after a stable key edge.
// Backpressure: none; presses arriving while busy or disabled are dropped. Optional: DRIVE_CMD_AUTO_REPEAT_EN.
module drive_cmd_sequencer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETUP_CYCLES    = 4,
    parameter int STROBE_CYCLES   = 4,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    drive_cmd_sequencer_if.master cmd
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PH_MAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);

    localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PH_W-1:0] SETUP_LAST  = PH_W'(SETUP_CYCLES - 1);
    localparam logic [PH_W-1:0] STROBE_LAST = PH_W'(STROBE_CYCLES - 1);

    // Released/low level of {sw_enable, key_n[3:0]}: keys high (released), enable low.
    localparam logic [4:0] IN_RST = 5'b0_1111;

    // Zero-length setup or strobe would collapse the hold-before/after guarantee.
    if (DEBOUNCE_CYCLES < 1 || SETUP_CYCLES < 1 || STROBE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("drive_cmd_sequencer: all cycle parameters must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_STROBE,
        ST_HOLDOFF
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [4:0] in_sync1, in_sync2;   // {sw_enable, key_n}
    logic [2:0] tq_sync1, tq_sync2;

    // Two-flop synchronisers for every raw board input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_sync1 <= IN_RST;
            in_sync2 <= IN_RST;
            tq_sync1 <= '0;
            tq_sync2 <= '0;
        end else begin
            in_sync1 <= {cmd.sw_enable, cmd.key_n};
            in_sync2 <= in_sync1;
            tq_sync1 <= cmd.sw_torque;
            tq_sync2 <= tq_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Debouncers (one counter per key and for sw_enable)
    // ------------------------------------------------------------------
    logic [4:0]      acc;              // accepted levels
    logic [3:0]      key_acc_d;        // accepted key levels one cycle ago
    logic [DB_W-1:0] db_cnt [5];

    // Accept a new level only after it has disagreed with the current one for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= IN_RST;
            key_acc_d <= IN_RST[3:0];
            for (int i = 0; i < 5; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            key_acc_d <= acc[3:0];
            for (int i = 0; i < 5; i++) begin
                if (in_sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    acc[i]    <= in_sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [3:0] key_acc;
    logic [3:0] press;
    logic       en_acc;
    logic       keys_released;
    logic [1:0] win_key;
    logic [2:0] tq_clamped;

    assign key_acc       = acc[3:0];
    assign en_acc        = acc[4];
    assign press         = key_acc_d & ~key_acc;   // accepted 1->0, one-cycle pulse
    assign keys_released = &key_acc;
    assign tq_clamped    = (tq_sync2 > 3'd4) ? 3'd4 : tq_sync2;

    // Simultaneous presses resolve fwd > back > left > right.
    always_comb begin
        win_key = 2'd3;
        if (press[0]) begin
            win_key = 2'd0;
        end else if (press[1]) begin
            win_key = 2'd1;
        end else if (press[2]) begin
            win_key = 2'd2;
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    state_t          state, state_nxt;
    logic [PH_W-1:0] ph_cnt, ph_cnt_nxt;
    logic            load_instr;   // new press: take instruction from winning key
    logic            load_cmd;     // any issue: resample torque, count command

    logic [1:0] instr_q;
    logic [2:0] torque_q;
    logic [7:0] cmd_cnt_q;
    logic       read_enable_q;
    logic       busy_q;

`ifdef DRIVE_CMD_AUTO_REPEAT_EN
    localparam int RP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [RP_W-1:0] REPEAT_LAST = RP_W'(REPEAT_CYCLES - 1);

    logic [RP_W-1:0] rep_cnt, rep_cnt_nxt;

    // Repeat timer: counts HOLDOFF cycles while the issuing key stays held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt_nxt;
        end
    end
`endif

    // State and phase counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ph_cnt <= '0;
        end else begin
            state  <= state_nxt;
            ph_cnt <= ph_cnt_nxt;
        end
    end

    // Next-state logic: issue on press, hold for setup, strobe, then wait for all keys released.
    always_comb begin
        state_nxt  = state;
        ph_cnt_nxt = ph_cnt;
        load_instr = 1'b0;
        load_cmd   = 1'b0;
`ifdef DRIVE_CMD_AUTO_REPEAT_EN
        rep_cnt_nxt = '0;
`endif
        case (state)
            ST_IDLE: begin
                if (|press && en_acc) begin
                    state_nxt  = ST_ISSUE;
                    ph_cnt_nxt = '0;
                    load_instr = 1'b1;
                    load_cmd   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (ph_cnt == SETUP_LAST) begin
                    state_nxt  = ST_STROBE;
                    ph_cnt_nxt = '0;
                end else begin
                    ph_cnt_nxt = ph_cnt + 1'b1;
                end
            end
            ST_STROBE: begin
                if (ph_cnt == STROBE_LAST) begin
                    state_nxt  = ST_HOLDOFF;
                    ph_cnt_nxt = '0;
                end else begin
                    ph_cnt_nxt = ph_cnt + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (keys_released) begin
                    state_nxt = ST_IDLE;
                end
`ifdef DRIVE_CMD_AUTO_REPEAT_EN
                else if (!key_acc[instr_q]) begin
                    if (rep_cnt == REPEAT_LAST) begin
                        state_nxt  = ST_ISSUE;
                        ph_cnt_nxt = '0;
                        load_cmd   = 1'b1;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Command outputs: instruction/torque change only on issue; strobe and busy are glitch-free flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q       <= 2'd0;
            torque_q      <= 3'd0;
            cmd_cnt_q     <= 8'd0;
            read_enable_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            if (load_instr) begin
                instr_q <= win_key;
            end
            if (load_cmd) begin
                torque_q  <= tq_clamped;
                cmd_cnt_q <= cmd_cnt_q + 8'd1;
            end
            read_enable_q <= (state_nxt == ST_STROBE);
            busy_q        <= (state_nxt != ST_IDLE);
        end
    end

    assign cmd.instruction = instr_q;
    assign cmd.torque      = torque_q;
    assign cmd.read_enable = read_enable_q;
    assign cmd.enable      = en_acc;
    assign cmd.busy        = busy_q;
    assign cmd.cmd_count   = cmd_cnt_q;

endmodule

// File: tb/tb_drive_cmd_sequencer.sv
// Bench for drive_cmd_sequencer: directed key/switch scenarios, checked every cycle against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_drive_cmd_sequencer;

    localparam int D  = 4;     // DEBOUNCE_CYCLES
    localparam int S  = 2;     // SETUP_CYCLES
    localparam int T  = 3;     // STROBE_CYCLES
    localparam int R  = 20;    // REPEAT_CYCLES
    localparam int HN = 8192;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    drive_cmd_sequencer_if dif();

    drive_cmd_sequencer #(
        .DEBOUNCE_CYCLES(D),
        .SETUP_CYCLES   (S),
        .STROBE_CYCLES  (T),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cmd  (dif.master)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: raw input history per cycle; accepted level flips when the
    // synchronised value (raw two cycles earlier) has been the opposite
    // level for D consecutive cycles. Command timing is a timeline
    // relative to the issue cycle.
    // ------------------------------------------------------------------
    logic [3:0] h_key [HN];
    logic       h_en  [HN];
    logic [2:0] h_tq  [HN];
    int         n;
    logic [4:0] m_acc, m_acc_last;
    logic       m_busy, m_re;
    int         m_issue, m_run;
    logic [1:0] m_instr;
    logic [2:0] m_tq;
    logic [7:0] m_cnt;

    function automatic logic raw_val(int i, int b);
        if (i < 0) return (b == 4) ? 1'b0 : 1'b1;
        if (b == 4) return h_en[i];
        return h_key[i][b];
    endfunction

    function automatic logic [2:0] raw_tq(int i);
        if (i < 0) return 3'd0;
        return h_tq[i];
    endfunction

    function automatic logic [2:0] clamp4(logic [2:0] v);
        return (v > 3'd4) ? 3'd4 : v;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0; m_acc = 5'b01111; m_acc_last = 5'b01111;
            m_busy = 0; m_re = 0; m_issue = 0; m_run = 0;
            m_instr = 0; m_tq = 0; m_cnt = 0;
        end else begin
            logic [3:0] press;
            logic [4:0] nxt;
            h_key[n] = dif.key_n; h_en[n] = dif.sw_enable; h_tq[n] = dif.sw_torque;
            press = m_acc_last[3:0] & ~m_acc[3:0];
            if (!m_busy) begin
                if (press != 0 && m_acc[4]) begin
                    for (int b = 3; b >= 0; b--) if (press[b]) m_instr = 2'(b);
                    m_busy = 1; m_issue = n; m_run = 0;
                    m_tq = clamp4(raw_tq(n - 2)); m_cnt = m_cnt + 1;
                end
            end else if (n - 1 - m_issue >= S + T) begin
                if (m_acc[3:0] == 4'hF) begin
                    m_busy = 0; m_run = 0;
                end else begin
`ifdef DRIVE_CMD_AUTO_REPEAT_EN
                    if (!m_acc[m_instr]) begin
                        m_run++;
                        if (m_run == R) begin
                            m_issue = n; m_run = 0;
                            m_tq = clamp4(raw_tq(n - 2)); m_cnt = m_cnt + 1;
                        end
                    end else begin
                        m_run = 0;
                    end
`endif
                end
            end
            nxt = m_acc;
            for (int b = 0; b < 5; b++) begin
                logic flip;
                flip = 1;
                for (int j = 0; j < D; j++)
                    if (raw_val(n - 2 - j, b) == m_acc[b]) flip = 0;
                if (flip) nxt[b] = ~m_acc[b];
            end
            m_acc_last = m_acc;
            m_acc = nxt;
            m_re = m_busy && (n - m_issue >= S) && (n - m_issue < S + T);
            if (n < HN - 1) n++;
        end
    end

    // ------------------------------------------------------------------
    // Per-cycle compare and strobe monitor
    // ------------------------------------------------------------------
    logic model_on = 1'b0;
    logic re_prev  = 1'b0;
    int   cyc      = 0;
    int   rises    = 0;
    int   rise_t [64];

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            re_prev = 1'b0;
        end else if (model_on) begin
            chk("cyc_read_enable", dif.read_enable, m_re);
            chk("cyc_busy",        dif.busy,        m_busy);
            chk("cyc_enable",      dif.enable,      m_acc[4]);
            chk("cyc_instruction", dif.instruction, m_instr);
            chk("cyc_torque",      dif.torque,      m_tq);
            chk("cyc_cmd_count",   dif.cmd_count,   m_cnt);
            if (dif.read_enable && !re_prev) begin
                if (rises < 64) rise_t[rises] = cyc;
                rises++;
            end
            re_prev = dif.read_enable;
        end
    end

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        dif.key_n = 4'hF; dif.sw_enable = 1'b0; dif.sw_torque = 3'd0;
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    // Counts falling edges until read_enable is seen high (bounded).
    task automatic wait_re(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!dif.read_enable && lat < 200);
        chk("re_seen", dif.read_enable, 1);
    endtask

    initial begin
        int lat, w, r0;
        dif.key_n = 4'hF; dif.sw_enable = 1'b0; dif.sw_torque = 3'd0;
        cycles(3);
        chk("rst_instruction", dif.instruction, 0);
        chk("rst_torque",      dif.torque,      0);
        chk("rst_read_enable", dif.read_enable, 0);
        chk("rst_enable",      dif.enable,      0);
        chk("rst_busy",        dif.busy,        0);
        chk("rst_cmd_count",   dif.cmd_count,   0);
        model_on = 1'b1;
        rst_n = 1'b1;

        // 1: single forward press
        do_reset();
        dif.sw_enable = 1'b1; dif.sw_torque = 3'd3;
        cycles(10);
        chk("t1_enable", dif.enable, 1);
        dif.key_n[0] = 1'b0;
        wait_re(lat);
        chk("t1_latency",     lat, 9);
        chk("t1_instruction", dif.instruction, 0);
        chk("t1_torque",      dif.torque, 3);
        chk("t1_cmd_count",   dif.cmd_count, 1);
        w = 0;
        while (dif.read_enable && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("t1_strobe_width", w, 3);
        cycles(10);
        chk("t1_busy_held", dif.busy, 1);
        dif.key_n = 4'hF;
        cycles(8);
        chk("t1_busy_released", dif.busy, 0);

        // 2: bouncing left key
        do_reset();
        dif.sw_enable = 1'b1;
        cycles(10);
        r0 = rises;
        for (int i = 0; i < 6; i++) begin
            dif.key_n[2] = (i % 2 == 0) ? 1'b0 : 1'b1;
            cycles(2);
        end
        dif.key_n[2] = 1'b0;
        wait_re(lat);
        chk("t2_latency",     lat, 9);
        chk("t2_instruction", dif.instruction, 2);
        cycles(10);
        chk("t2_cmd_count", dif.cmd_count, 1);
        chk("t2_strobes",   rises - r0, 1);
        dif.key_n = 4'hF;
        cycles(10);

        // 3: back and right together
        do_reset();
        dif.sw_enable = 1'b1;
        cycles(10);
        r0 = rises;
        dif.key_n = 4'b0101;
        wait_re(lat);
        chk("t3_instruction", dif.instruction, 1);
        cycles(8);
        dif.key_n = 4'hF;
        cycles(10);
        chk("t3_strobes",   rises - r0, 1);
        chk("t3_cmd_count", dif.cmd_count, 1);

        // 4: torque clamp, then disabled press
        do_reset();
        dif.sw_enable = 1'b1; dif.sw_torque = 3'd7;
        cycles(10);
        dif.key_n = 4'b0111;
        wait_re(lat);
        chk("t4_torque",      dif.torque, 4);
        chk("t4_instruction", dif.instruction, 3);
        cycles(5);
        dif.key_n = 4'hF;
        cycles(10);
        chk("t4_idle", dif.busy, 0);
        dif.sw_enable = 1'b0;
        cycles(10);
        chk("t4_enable_low", dif.enable, 0);
        r0 = rises;
        dif.key_n = 4'b1110;
        cycles(30);
        chk("t4_no_strobe",       rises - r0, 0);
        chk("t4_cmd_count",       dif.cmd_count, 1);
        chk("t4_instr_held",      dif.instruction, 3);
        chk("t4_torque_held",     dif.torque, 4);
        chk("t4_busy_disabled",   dif.busy, 0);
        dif.key_n = 4'hF;
        cycles(10);

        // 5: reset during the second strobe cycle
        do_reset();
        dif.sw_enable = 1'b1; dif.sw_torque = 3'd2;
        cycles(10);
        dif.key_n[0] = 1'b0;
        wait_re(lat);
        @(posedge clk);
        #1;
        chk("t5_re_before_rst", dif.read_enable, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_read_enable", dif.read_enable, 0);
        chk("t5_instruction", dif.instruction, 0);
        chk("t5_torque",      dif.torque, 0);
        chk("t5_cmd_count",   dif.cmd_count, 0);
        chk("t5_busy",        dif.busy, 0);
        chk("t5_enable",      dif.enable, 0);
        dif.key_n = 4'hF;
        cycles(3);
        rst_n = 1'b1;
        cycles(5);

        // 6: long forward hold
        do_reset();
        dif.sw_enable = 1'b1; dif.sw_torque = 3'd1;
        cycles(10);
        r0 = rises;
        dif.key_n[0] = 1'b0;
        wait_re(lat);
        cycles(60);
        dif.key_n = 4'hF;
        cycles(15);
`ifdef DRIVE_CMD_AUTO_REPEAT_EN
        chk("t6_strobes",   rises - r0, 3);
        chk("t6_cmd_count", dif.cmd_count, 3);
        chk("t6_period",    rise_t[r0 + 1] - rise_t[r0], 25);
        chk("t6_period2",   rise_t[r0 + 2] - rise_t[r0 + 1], 25);
`else
        chk("t6_strobes",   rises - r0, 1);
        chk("t6_cmd_count", dif.cmd_count, 1);
`endif
        chk("t6_idle", dif.busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
